// File: rtl/ysyx_25040111_cache_axi_rd.sv
// Read-only bridge from the I-cache refill port to AXI4 AR/R channels.
// One outstanding request; single-beat or INCR-burst refill selected by BURST_EN.
//
// state  | meaning
// S_IDLE | waiting for rstart from the cache
// S_AR   | arvalid held with latched araddr/arlen until arready
// S_R    | rready high, collecting beats until the last one
module ysyx_25040111_cache_axi_rd #(
    parameter bit         BURST_EN = 1'b0,
    parameter logic [3:0] AXI_ID   = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rstart,
    input  logic [31:0] raddr,
    input  logic [7:0]  rlen,
    output logic        rok,
    output logic [31:0] rdata_o,
    output logic        err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] beat;
    logic       ar_fire;
    logic       r_fire;
    logic       last_beat;
    logic       busy_req;
    logic       beat_err;

    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arid    = AXI_ID;

    assign ar_fire   = arvalid && arready;
    assign r_fire    = rready && rvalid;
    assign last_beat = BURST_EN ? (beat == arlen) : 1'b1;

    // In burst mode the cache re-pulses rstart after every word; that is benign in S_R.
    assign busy_req = rstart && ((state == S_AR) || ((state == S_R) && !BURST_EN));
    assign beat_err = r_fire && ((rresp != 2'b00) || (rid != AXI_ID) || (rlast != (beat == arlen)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rstart) state_nxt = S_AR;
            S_AR:    if (ar_fire) state_nxt = S_R;
            S_R:     if (r_fire && last_beat) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        case (state)
            S_AR:    arvalid = 1'b1;
            S_R:     rready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rok     <= 1'b0;
            rdata_o <= 32'h0;
            err     <= 1'b0;
            araddr  <= 32'h0;
            arlen   <= 8'h0;
            beat    <= 8'h0;
        end else begin
            rok <= r_fire;
            if ((state == S_IDLE) && rstart) begin
                araddr <= raddr;
                arlen  <= BURST_EN ? rlen : 8'h0;
                beat   <= 8'h0;
            end
            // beat may wrap after a 256-beat burst, but the FSM has already left S_R
            if (r_fire) begin
                rdata_o <= rdata;
                beat    <= beat + 8'd1;
            end
            if (busy_req || beat_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_cache_axi_rd.sv
// Bench for the cache AXI read bridge: instance 0 is single-beat mode, instance 1 burst mode.
// Acts as both cache and AXI slave; expectations come from a per-transaction reference model.
module tb_ysyx_25040111_cache_axi_rd;

    logic        clock = 1'b0;
    logic        reset;
    logic        rstart  [2];
    logic [31:0] raddr   [2];
    logic [7:0]  rlen    [2];
    logic        rok     [2];
    logic [31:0] rdata_o [2];
    logic        err     [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [7:0]  arlen   [2];
    logic [2:0]  arsize  [2];
    logic [1:0]  arburst [2];
    logic [3:0]  arid    [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rlast   [2];
    logic [3:0]  rid     [2];

    logic        err_exp [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_25040111_cache_axi_rd #(
            .BURST_EN (g == 1),
            .AXI_ID   ((g == 1) ? 4'h5 : 4'h0)
        ) u_dut (
            .clock   (clock),
            .reset   (reset),
            .rstart  (rstart[g]),
            .raddr   (raddr[g]),
            .rlen    (rlen[g]),
            .rok     (rok[g]),
            .rdata_o (rdata_o[g]),
            .err     (err[g]),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .arlen   (arlen[g]),
            .arsize  (arsize[g]),
            .arburst (arburst[g]),
            .arid    (arid[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rlast   (rlast[g]),
            .rid     (rid[g])
        );
    end

    function automatic logic [3:0] id_of(input int m);
        return (m == 1) ? 4'h5 : 4'h0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
    endtask

    // One complete refill as seen by the cache and slave. ekind: 0 none, 1 rresp, 2 rlast, 3 rid.
    task automatic txn(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input int ar_wait, input int gap_hi, input logic [31:0] d0,
                       input logic [31:0] dstep, input int ekind, input int ebeat,
                       input bit ar_poke);
        int          nb;
        int          gap;
        logic [31:0] w;
        logic [7:0]  exp_len;
        nb      = (m == 1) ? int'(len) + 1 : 1;
        exp_len = (m == 1) ? len : 8'h0;
        rstart[m] = 1'b1;
        raddr[m]  = addr;
        rlen[m]   = len;
        tick();
        rstart[m] = 1'b0;
        raddr[m]  = $urandom;
        rlen[m]   = 8'($urandom);
        for (int i = 0; i <= ar_wait; i++) begin
            check_val("ar_valid", 32'(arvalid[m]), 32'd1);
            check_val("ar_addr", araddr[m], addr);
            check_val("ar_len", 32'(arlen[m]), 32'(exp_len));
            check_val("no_early_rok", 32'(rok[m]), 32'd0);
            check_val("ar_err", 32'(err[m]), 32'(err_exp[m]));
            if (ar_poke && i == 0) rstart[m] = 1'b1;
            if (i == ar_wait) arready[m] = 1'b1;
            tick();
            if (ar_poke && i == 0) begin
                rstart[m]  = 1'b0;
                err_exp[m] = 1'b1;
            end
        end
        arready[m] = 1'b0;
        check_val("ar_drop", 32'(arvalid[m]), 32'd0);
        check_val("r_ready", 32'(rready[m]), 32'd1);
        for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(gap_hi, 0);
            repeat (gap) tick();
            w         = d0 + 32'(b) * dstep;
            rvalid[m] = 1'b1;
            rdata[m]  = w;
            rresp[m]  = (ekind == 1 && b == ebeat) ? 2'b10 : 2'b00;
            rid[m]    = (ekind == 3 && b == ebeat) ? ~id_of(m) : id_of(m);
            rlast[m]  = (b == nb - 1) != (ekind == 2 && b == ebeat);
            tick();
            rvalid[m] = 1'b0;
            rlast[m]  = 1'b0;
            rresp[m]  = 2'b00;
            rid[m]    = id_of(m);
            rdata[m]  = $urandom;
            if (ekind != 0 && b == ebeat) err_exp[m] = 1'b1;
            check_val("rok_pulse", 32'(rok[m]), 32'd1);
            check_val("rok_data", rdata_o[m], w);
            check_val("beat_err", 32'(err[m]), 32'(err_exp[m]));
            if (m == 1 && b < nb - 1) begin
                rstart[m] = 1'b1;
                raddr[m]  = $urandom;
                tick();
                rstart[m] = 1'b0;
                check_val("r_stay", 32'(rready[m]), 32'd1);
                check_val("repulse_err", 32'(err[m]), 32'(err_exp[m]));
            end else begin
                tick();
            end
            check_val("rok_once", 32'(rok[m]), 32'd0);
            check_val("rdata_hold", rdata_o[m], w);
        end
        check_val("idle_rready", 32'(rready[m]), 32'd0);
        check_val("idle_arvalid", 32'(arvalid[m]), 32'd0);
        check_val("end_err", 32'(err[m]), 32'(err_exp[m]));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstart[i]  = 1'b0;
            raddr[i]   = 32'h0;
            rlen[i]    = 8'h0;
            arready[i] = 1'b0;
            rvalid[i]  = 1'b0;
            rdata[i]   = 32'h0;
            rresp[i]   = 2'b00;
            rlast[i]   = 1'b0;
            rid[i]     = id_of(i);
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check_val("rst_arvalid", 32'(arvalid[i]), 32'd0);
            check_val("rst_rready", 32'(rready[i]), 32'd0);
            check_val("rst_rok", 32'(rok[i]), 32'd0);
            check_val("rst_rdata_o", rdata_o[i], 32'h0);
            check_val("rst_err", 32'(err[i]), 32'd0);
            check_val("rst_araddr", araddr[i], 32'h0);
            check_val("rst_arlen", 32'(arlen[i]), 32'd0);
            check_val("arsize", 32'(arsize[i]), 32'd2);
            check_val("arburst", 32'(arburst[i]), 32'd1);
            check_val("arid", 32'(arid[i]), 32'(id_of(i)));
        end

        // single beat, then AR backpressure, then the reference burst
        txn(0, 32'h8000_0010, 8'd0, 0, 2, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        txn(0, 32'h8000_0040, 8'd0, 5, 2, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
        txn(1, 32'h8000_0100, 8'd3, 0, 3, 32'h11, 32'h11, 0, 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            txn(int'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(15, 0)),
                int'($urandom_range(3, 0)), 2, $urandom, $urandom, 0, 0, 1'b0);
        end

        // maximum burst length: 256 beats, beat counter must not wrap early
        txn(1, 32'h8000_1000, 8'd255, 0, 0, $urandom, 32'd4, 0, 0, 1'b0);

        // error responses; err must stay set across a following clean refill
        txn(1, 32'h8000_0200, 8'd3, 0, 1, 32'h100, 32'd1, 1, 2, 1'b0);
        txn(1, 32'h8000_0240, 8'd3, 0, 1, 32'h200, 32'd1, 0, 0, 1'b0);
        do_reset();
        txn(1, 32'h8000_0280, 8'd3, 0, 1, 32'h300, 32'd1, 2, 1, 1'b0);
        do_reset();
        txn(0, 32'h8000_02C0, 8'd0, 0, 1, 32'h400, 32'd0, 3, 0, 1'b0);
        do_reset();
        txn(0, 32'h8000_0300, 8'd0, 0, 1, 32'h500, 32'd0, 2, 0, 1'b0);
        do_reset();
        txn(1, 32'h8000_0340, 8'd2, 2, 1, 32'h600, 32'd1, 0, 0, 1'b1);
        do_reset();

        // single mode: rstart while in R is dropped and flagged
        rstart[0] = 1'b1;
        raddr[0]  = 32'h8000_0400;
        tick();
        rstart[0]  = 1'b0;
        arready[0] = 1'b1;
        tick();
        arready[0] = 1'b0;
        check_val("busy_in_r", 32'(rready[0]), 32'd1);
        rstart[0] = 1'b1;
        raddr[0]  = 32'h8000_0500;
        tick();
        rstart[0] = 1'b0;
        check_val("busy_err", 32'(err[0]), 32'd1);
        check_val("busy_no_ar", 32'(arvalid[0]), 32'd0);
        rvalid[0] = 1'b1;
        rdata[0]  = 32'hCAFE_F00D;
        rlast[0]  = 1'b1;
        tick();
        rvalid[0] = 1'b0;
        rlast[0]  = 1'b0;
        check_val("busy_rok", 32'(rok[0]), 32'd1);
        check_val("busy_data", rdata_o[0], 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("busy_no_ar2", 32'(arvalid[0]), 32'd0);
        end
        check_val("busy_araddr", araddr[0], 32'h8000_0400);

        // reset in the middle of a burst, then a fresh refill
        rstart[1] = 1'b1;
        raddr[1]  = 32'h8000_0600;
        rlen[1]   = 8'd3;
        tick();
        rstart[1]  = 1'b0;
        arready[1] = 1'b1;
        tick();
        arready[1] = 1'b0;
        rvalid[1]  = 1'b1;
        rdata[1]   = 32'h1;
        rresp[1]   = 2'b10;
        tick();
        rresp[1]  = 2'b00;
        rdata[1]  = 32'h2;
        check_val("mid_rok", 32'(rok[1]), 32'd1);
        check_val("mid_err", 32'(err[1]), 32'd1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        rvalid[1] = 1'b0;
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        check_val("mr_arvalid", 32'(arvalid[1]), 32'd0);
        check_val("mr_rready", 32'(rready[1]), 32'd0);
        check_val("mr_rok", 32'(rok[1]), 32'd0);
        check_val("mr_err", 32'(err[1]), 32'd0);
        check_val("mr_rdata_o", rdata_o[1], 32'h0);
        check_val("mr_araddr", araddr[1], 32'h0);
        check_val("mr_arlen", 32'(arlen[1]), 32'd0);
        txn(1, 32'h8000_0700, 8'd3, 1, 1, 32'hA0, 32'h10, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
